// File: rtl/bg_tile_fetch.sv
// Background tile fetcher: for each tile of a scanline, reads the nametable, attribute,
// pattern and palette bytes from VRAM, then hands them to an 8-pixel renderer and waits for it.
module bg_tile_fetch #(
    parameter int NUM_TILES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  scanline,
    input  logic [1:0]  nt_sel,
    input  logic        pt_sel,
    output logic [13:0] vram_addr,
    output logic        vram_rd_en,
    input  logic [7:0]  vram_rdata,
    output logic [8:0]  vga_start_row,
    output logic [8:0]  vga_start_col,
    output logic [7:0]  pattern_low,
    output logic [7:0]  pattern_high,
    output logic [7:0]  color_1,
    output logic [7:0]  color_2,
    output logic [7:0]  color_3,
    output logic        render_start,
    input  logic        render_busy,
    output logic        busy,
    output logic        done
);

    // state    | meaning
    // IDLE     | waiting for start
    // FETCH    | 7 reads (NT, AT, PLO, PHI, C1..C3), each issue + capture cycle
    // DISPATCH | render_start pulse for the fetched tile
    // WAIT_HI  | waiting for the renderer to report busy
    // WAIT_LO  | waiting for the renderer to finish
    // DONE     | one-cycle done pulse, then back to IDLE
    typedef enum logic [2:0] {IDLE, FETCH, DISPATCH, WAIT_HI, WAIT_LO, DONE} state_t;

    localparam logic [4:0] LAST_COL = 5'(NUM_TILES - 1);

    state_t      state;
    logic [7:0]  sl_q;
    logic [1:0]  nt_q;
    logic        pt_q;
    logic [4:0]  col;
    logic [4:0]  col_nxt;
    logic [2:0]  rd_idx;
    logic        phase;
    logic [7:0]  nt_byte;
    logic [7:0]  at_byte;
    logic [1:0]  pal;
    logic [13:0] next_addr;

    function automatic logic [13:0] nt_addr(input logic [4:0] row, input logic [1:0] nt,
                                            input logic [4:0] c);
        return {2'b10, nt, row, c};
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7 - i];
        return r;
    endfunction

    assign col_nxt = col + 5'd1;

    always_comb begin
        pal = 2'd0;
        case ({sl_q[4], col[1]})
            2'b00:   pal = at_byte[1:0];
            2'b01:   pal = at_byte[3:2];
            2'b10:   pal = at_byte[5:4];
            default: pal = at_byte[7:6];
        endcase
    end

    // Address of the read that follows the one captured at rd_idx.
    always_comb begin
        next_addr = 14'd0;
        case (rd_idx)
            3'd0:    next_addr = {2'b10, nt_q, 4'b1111, sl_q[7:5], col[4:2]};
            3'd1:    next_addr = {1'b0, pt_q, nt_byte, 1'b0, sl_q[2:0]};
            3'd2:    next_addr = {1'b0, pt_q, nt_byte, 1'b1, sl_q[2:0]};
            3'd3:    next_addr = {6'h3F, 4'h0, pal, 2'd1};
            3'd4:    next_addr = {6'h3F, 4'h0, pal, 2'd2};
            default: next_addr = {6'h3F, 4'h0, pal, 2'd3};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sl_q          <= '0;
            nt_q          <= '0;
            pt_q          <= 1'b0;
            col           <= '0;
            rd_idx        <= '0;
            phase         <= 1'b0;
            nt_byte       <= '0;
            at_byte       <= '0;
            vram_addr     <= '0;
            vram_rd_en    <= 1'b0;
            vga_start_row <= '0;
            vga_start_col <= '0;
            pattern_low   <= '0;
            pattern_high  <= '0;
            color_1       <= '0;
            color_2       <= '0;
            color_3       <= '0;
            render_start  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sl_q          <= scanline[7:0];
                        nt_q          <= nt_sel;
                        pt_q          <= pt_sel;
                        col           <= '0;
                        rd_idx        <= '0;
                        phase         <= 1'b0;
                        busy          <= 1'b1;
                        vga_start_row <= scanline;
                        vga_start_col <= '0;
                        if (scanline >= 9'd240) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            vram_rd_en <= 1'b1;
                            vram_addr  <= nt_addr(scanline[7:3], nt_sel, 5'd0);
                        end
                    end
                end
                FETCH: begin
                    if (!phase) begin
                        vram_rd_en <= 1'b0;
                        phase      <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        case (rd_idx)
                            3'd0:    nt_byte      <= vram_rdata;
                            3'd1:    at_byte      <= vram_rdata;
                            3'd2:    pattern_low  <= rev8(vram_rdata);
                            3'd3:    pattern_high <= rev8(vram_rdata);
                            3'd4:    color_1      <= vram_rdata;
                            3'd5:    color_2      <= vram_rdata;
                            default: color_3      <= vram_rdata;
                        endcase
                        if (rd_idx == 3'd6) begin
                            state        <= DISPATCH;
                            render_start <= 1'b1;
                        end else begin
                            rd_idx     <= rd_idx + 3'd1;
                            vram_rd_en <= 1'b1;
                            vram_addr  <= next_addr;
                        end
                    end
                end
                DISPATCH: begin
                    render_start <= 1'b0;
                    state        <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (render_busy) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!render_busy) begin
                        if (col == LAST_COL) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            col           <= col_nxt;
                            vga_start_col <= {1'b0, col_nxt, 3'b000};
                            rd_idx        <= '0;
                            vram_rd_en    <= 1'b1;
                            vram_addr     <= nt_addr(sl_q[7:3], nt_q, col_nxt);
                            state         <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_tile_fetch.sv
// Scoreboard bench for bg_tile_fetch: a VRAM model and an 8-cycle renderer model, expected
// reads/tiles/done pulses queued by the stimulus and checked by a negedge monitor.
module tb_bg_tile_fetch;

    typedef struct packed {
        logic [8:0] row;
        logic [8:0] col;
        logic [7:0] plo;
        logic [7:0] phi;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] c3;
    } tile_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  scanline = '0;
    logic [1:0]  nt_sel = '0;
    logic        pt_sel = 1'b0;
    logic [13:0] vram_addr;
    logic        vram_rd_en;
    logic [7:0]  vram_rdata = '0;
    logic [8:0]  vga_start_row, vga_start_col;
    logic [7:0]  pattern_low, pattern_high, color_1, color_2, color_3;
    logic        render_start;
    logic        render_busy;
    logic        busy, done;

    logic [7:0]  vram [0:16383];
    int          rb_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          rs_count = 0;
    int          exp_done = 0;
    logic [13:0] exp_rd[$];
    tile_t       exp_tile[$];
    tile_t       snap;
    bit          hold = 0;
    tile_t       cur;

    bg_tile_fetch #(.NUM_TILES(32)) dut (
        .clk(clk), .rst(rst), .start(start), .scanline(scanline), .nt_sel(nt_sel),
        .pt_sel(pt_sel), .vram_addr(vram_addr), .vram_rd_en(vram_rd_en),
        .vram_rdata(vram_rdata), .vga_start_row(vga_start_row),
        .vga_start_col(vga_start_col), .pattern_low(pattern_low),
        .pattern_high(pattern_high), .color_1(color_1), .color_2(color_2),
        .color_3(color_3), .render_start(render_start), .render_busy(render_busy),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (vram_rd_en) vram_rdata <= vram[vram_addr];

    always @(posedge clk) begin
        if (render_start) rb_cnt <= 8;
        else if (rb_cnt != 0) rb_cnt <= rb_cnt - 1;
    end
    assign render_busy = (rb_cnt != 0);

    assign cur = '{vga_start_row, vga_start_col, pattern_low, pattern_high,
                   color_1, color_2, color_3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7 - i];
        return r;
    endfunction

    // Reference model straight from the address formulas.
    task automatic push_tile(input int sl, input int nt, input int pt, input int col);
        int nta, ata, ploa, phia, shift, pal;
        tile_t t;
        nta   = 'h2000 | (nt << 10) | (((sl >> 3) & 31) << 5) | col;
        ata   = 'h23C0 | (nt << 10) | ((((sl >> 3) & 31) >> 2) << 3) | (col >> 2);
        ploa  = (pt << 12) | (int'(vram[nta]) << 4) | (sl & 7);
        phia  = ploa | 8;
        shift = ((sl >> 4) & 1) * 4 + ((col >> 1) & 1) * 2;
        pal   = (int'(vram[ata]) >> shift) & 3;
        exp_rd.push_back(14'(nta));
        exp_rd.push_back(14'(ata));
        exp_rd.push_back(14'(ploa));
        exp_rd.push_back(14'(phia));
        for (int n = 1; n <= 3; n++) exp_rd.push_back(14'('h3F00 | (pal << 2) | n));
        t.row = 9'(sl);
        t.col = 9'(col * 8);
        t.plo = rev8(vram[ploa]);
        t.phi = rev8(vram[phia]);
        t.c1  = vram['h3F00 | (pal << 2) | 1];
        t.c2  = vram['h3F00 | (pal << 2) | 2];
        t.c3  = vram['h3F00 | (pal << 2) | 3];
        exp_tile.push_back(t);
    endtask

    task automatic push_hand(input logic [13:0] a0, a1, a2, a3, a4, a5, a6, input tile_t t);
        exp_rd.push_back(a0); exp_rd.push_back(a1); exp_rd.push_back(a2);
        exp_rd.push_back(a3); exp_rd.push_back(a4); exp_rd.push_back(a5);
        exp_rd.push_back(a6);
        exp_tile.push_back(t);
    endtask

    task automatic do_start(input int sl, input int nt, input int pt);
        @(negedge clk);
        scanline = 9'(sl);
        nt_sel   = 2'(nt);
        pt_sel   = 1'(pt);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        chk({name, "_busy_at_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({name, "_busy_falls"}, 64'(busy), 64'd0);
    endtask

    // Monitor: consumes expected reads, tiles and done pulses as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            hold = 0;
        end else begin
            if (vram_rd_en || done) hold = 0;
            if (hold) chk("hold_outputs", 64'(cur), 64'(snap));
            if (vram_rd_en) begin
                if (exp_rd.size() == 0) chk("unexpected_read", 64'(vram_addr), 64'h4000);
                else chk("read_addr", 64'(vram_addr), 64'(exp_rd.pop_front()));
            end
            if (render_start) begin
                rs_count++;
                if (exp_tile.size() == 0) chk("unexpected_render_start", 64'(cur), 64'h1);
                else chk("tile_outputs", 64'(cur), 64'(exp_tile.pop_front()));
                snap = cur;
                hold = 1;
            end
            if (done) begin
                chk("done_expected", 64'(exp_done > 0), 64'd1);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'((i * 37 + 11) ^ (i >> 8));
        for (int i = 0; i < 16; i++) vram['h3F00 + i] = 8'('h20 + i);
        vram['h2000] = 8'h24;
        vram['h23C0] = 8'hE4;
        vram['h0240] = 8'h80;
        vram['h0248] = 8'h01;
        vram['h2442] = 8'h5A;
        vram['h27C0] = 8'hE4;
        vram['h15A1] = 8'h0F;
        vram['h15A9] = 8'hC3;

        repeat (3) @(negedge clk);
        chk("reset_ctl", 64'({vram_addr, vram_rd_en, render_start, busy, done}), 64'd0);
        chk("reset_data", 64'(cur), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // scanline 0: hand-checked first tile and its timing
        push_hand(14'h2000, 14'h23C0, 14'h0240, 14'h0248, 14'h3F01, 14'h3F02, 14'h3F03,
                  '{9'd0, 9'd0, 8'h01, 8'h80, 8'h21, 8'h22, 8'h23});
        for (int c = 1; c < 32; c++) push_tile(0, 0, 0, c);
        exp_done = 1;
        rs_count = 0;
        do_start(0, 0, 0);
        chk("busy_after_start", 64'(busy), 64'd1);
        repeat (14) @(negedge clk);
        chk("render_start_cycle14", 64'(render_start), 64'd0);
        @(negedge clk);
        chk("render_start_cycle15", 64'(render_start), 64'd1);
        chk("first_start_col", 64'(vga_start_col), 64'd0);
        wait_done("sl0");
        chk("sl0_pulses", 64'(rs_count), 64'd32);

        // scanline 17, nametable 1, pattern table 1: hand-checked tile 2
        push_tile(17, 1, 1, 0);
        push_tile(17, 1, 1, 1);
        push_hand(14'h2442, 14'h27C0, 14'h15A1, 14'h15A9, 14'h3F0D, 14'h3F0E, 14'h3F0F,
                  '{9'd17, 9'd16, 8'hF0, 8'hC3, 8'h2D, 8'h2E, 8'h2F});
        for (int c = 3; c < 32; c++) push_tile(17, 1, 1, c);
        exp_done = 1;
        do_start(17, 1, 1);
        wait_done("sl17");

        // scanline 5 full, with a start pulse while busy that must be ignored
        for (int c = 0; c < 32; c++) push_tile(5, 2, 0, c);
        exp_done = 1;
        rs_count = 0;
        do_start(5, 2, 0);
        repeat (40) @(negedge clk);
        scanline = 9'd200; nt_sel = 2'd3; pt_sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("sl5");
        chk("sl5_pulses", 64'(rs_count), 64'd32);

        // scanline 240: no reads, no render, done right away
        exp_done = 1;
        rs_count = 0;
        do_start(240, 0, 0);
        @(negedge clk);
        chk("sl240_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("sl240_done_off", 64'(done), 64'd0);
        chk("sl240_busy_off", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("sl240_no_render", 64'(rs_count), 64'd0);

        // reset during tile 10 WAIT_LO
        for (int c = 0; c <= 10; c++) push_tile(9, 2, 0, c);
        rs_count = 0;
        do_start(9, 2, 0);
        for (int n = 0; n < 2000 && rs_count < 11; n++) @(negedge clk);
        chk("reach_tile10", 64'(rs_count), 64'd11);
        repeat (2) @(negedge clk);
        scanline = 9'd100; start = 1'b1;
        @(negedge clk);
        chk("busy_in_wait_lo", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("midreset_ctl", 64'({vram_addr, vram_rd_en, render_start, busy, done}), 64'd0);
        chk("midreset_data", 64'(cur), 64'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_reset_idle", 64'(busy), 64'd0);
        chk("post_reset_no_render", 64'(rs_count), 64'd11);

        // resume with a new start at the last visible row
        for (int c = 0; c < 32; c++) push_tile(239, 3, 1, c);
        exp_done = 1;
        rs_count = 0;
        do_start(239, 3, 1);
        wait_done("sl239");
        chk("sl239_pulses", 64'(rs_count), 64'd32);

        repeat (3) @(negedge clk);
        chk("reads_drained", 64'(exp_rd.size()), 64'd0);
        chk("tiles_drained", 64'(exp_tile.size()), 64'd0);
        chk("dones_drained", 64'(exp_done), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bg_tile_fetch.md
BG_TILE_FETCH -- requirements
Module: bg_tile_fetch

Interface
REQ-001 SHALL have parameter NUM_TILES, default 32, tiles fetched and dispatched per scanline.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port start  input  1  request to fetch and render one scanline.
REQ-005 SHALL have port scanline  input  9  screen row 0..239, latched on accepted start.
REQ-006 SHALL have port nt_sel  input  2  nametable select, latched on accepted start.
REQ-007 SHALL have port pt_sel  input  1  background pattern table select (0=0x0000, 1=0x1000), latched on accepted start.
REQ-008 SHALL have port vram_addr  output  14  PPU address bus.
REQ-009 SHALL have port vram_rd_en  output  1  read strobe.
REQ-010 SHALL have port vram_rdata  input  8  read data, valid the cycle after vram_rd_en.
REQ-011 SHALL have ports vga_start_row, vga_start_col  output  9 each  renderer tile origin.
REQ-012 SHALL have ports pattern_low, pattern_high  output  8 each  renderer pattern bytes.
REQ-013 SHALL have ports color_1, color_2, color_3  output  8 each  resolved palette entries.
REQ-014 SHALL have port render_start  output  1  one-cycle start pulse to the 8-pixel renderer.
REQ-015 SHALL have port render_busy  input  1  renderer busy flag.
REQ-016 SHALL have ports busy  output  1  and done  output  1  (one-cycle end-of-scanline pulse).

Function
REQ-017 SHALL use states IDLE, FETCH (7 reads x 2 cycles), DISPATCH, WAIT_HI, WAIT_LO, DONE.
REQ-018 SHALL accept start only in IDLE; start at any other time SHALL be ignored.
REQ-019 SHALL drive busy=1 in every state other than IDLE.
REQ-020 SHALL perform each read as an issue cycle (vram_rd_en=1, vram_addr valid) followed by a capture cycle (vram_rd_en=0, vram_rdata registered).
REQ-021 SHALL read, in order, with row=scanline[7:3], fy=scanline[2:0], col = tile index 0..NUM_TILES-1:
 - NT: 0x2000 | nt_sel<<10 | row<<5 | col
 - AT: 0x23C0 | nt_sel<<10 | (row>>2)<<3 | (col>>2)
 - PLO: pt_sel<<12 | nt_byte<<4 | fy
 - PHI: pt_sel<<12 | nt_byte<<4 | 8 | fy
 - C1..C3: 0x3F00 | pal<<2 | n, n=1..3.
REQ-022 SHALL compute pal = AT byte bits [shift+1:shift], shift = scanline[4]*4 + col[1]*2.
REQ-023 SHALL bit-reverse PLO/PHI onto pattern_low/pattern_high so bit 0 is the leftmost pixel.
REQ-024 SHALL drive vga_start_row=scanline, vga_start_col=col*8 before DISPATCH.
REQ-025 SHALL assert render_start for exactly one cycle in DISPATCH, 15 cycles after the edge that accepted start (first tile) and 15 cycles after leaving WAIT_LO (subsequent tiles).
REQ-026 SHALL stay in WAIT_HI until render_busy=1, then WAIT_LO until render_busy=0.
REQ-027 SHALL hold all renderer outputs stable from DISPATCH until WAIT_LO exits.
REQ-028 SHALL, after tile NUM_TILES-1 completes, enter DONE, pulse done one cycle, return to IDLE.
REQ-029 SHALL, for latched scanline >= 240, issue no reads and no render_start, and pulse done one cycle after acceptance.
REQ-030 SHALL keep vram_rd_en=0 and render_start=0 outside issue and DISPATCH cycles respectively.

Reset
REQ-031 SHALL, on rst low at any time including mid-scanline, immediately force IDLE with busy, done, render_start, vram_rd_en = 0 and all address/data/color outputs = 0.
REQ-032 SHALL resume only on a new start after rst deasserts; no partial tile is dispatched.

Verification
REQ-033 scanline=0, nt_sel=0, pt_sel=0, NT[0x2000]=0x24, model renderer busy 8 cycles -> first reads 0x2000, 0x23C0, 0x0240, 0x0248; render_start at cycle 15; vga_start_col=0.
REQ-034 scanline=17, nt_sel=1, col 2, AT byte=0xE4 -> shift=6, pal=3, color reads 0x3F0D, 0x3F0E, 0x3F0F.
REQ-035 PLO=0x80, PHI=0x01 -> pattern_low=0x01, pattern_high=0x80.
REQ-036 full scanline 5 -> 32 render_start pulses, vga_start_col 0..248 step 8, single done pulse, busy falls with done.
REQ-037 scanline=240 -> no vram_rd_en, no render_start, done one cycle after start.
REQ-038 rst low during tile 10 WAIT_LO, start asserted while busy -> all outputs 0, IDLE; the start during busy is ignored, no done pulse.
